// File: rtl/sr_ff_exerciser.sv
// sr_ff_exerciser
//   Stimulus driver and checker for one SR flip-flop under test. A run steps
//   through a fixed table of six legal {r,s} vectors NUM_LOOPS times. Each
//   vector is driven for one cycle (DRIVE). It is then released to hold
//   (CHECK), and q/qbar are sampled at the edge leaving CHECK. Mismatches are
//   counted in a saturating counter, and the run ends in DONE with pass/fail.
//
// Ports
//   clk        clock, shared with the flop under test
//   rst        asynchronous active-high reset, shared with the flop
//   start      run request, honoured only in IDLE and DONE
//   s_out      registered set drive to the flop
//   r_out      registered reset drive to the flop
//   q_in       flop q
//   qbar_in    flop qbar
//   busy       high while in DRIVE or CHECK
//   done       high in DONE
//   pass       high in DONE when no mismatch was seen
//   err_count  saturating mismatch count for the current run
//   vec_idx    index of the vector currently applied (0..5)
module sr_ff_exerciser #(
    parameter int unsigned NUM_LOOPS = 1,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             s_out,
    output logic             r_out,
    input  logic             q_in,
    input  logic             qbar_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       vec_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic [2:0]       r_vec_idx, w_vec_idx;
    logic [3:0]       r_loop, w_loop;
    logic [ERR_W-1:0] r_err, w_err;
    logic             r_s, w_s;
    logic             r_r, w_r;
    logic             w_exp_q;
    logic             w_mismatch;

    // Vector table as {r,s}
    function automatic logic [1:0] vec_rs(input logic [2:0] idx);
        case (idx)
            3'd0:    vec_rs = 2'b01;
            3'd1:    vec_rs = 2'b00;
            3'd2:    vec_rs = 2'b10;
            3'd3:    vec_rs = 2'b00;
            3'd4:    vec_rs = 2'b01;
            3'd5:    vec_rs = 2'b10;
            default: vec_rs = 2'b00;
        endcase
    endfunction

    // Expected q after the vector at idx has been captured
    function automatic logic vec_q(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd4: vec_q = 1'b1;
            default:          vec_q = 1'b0;
        endcase
    endfunction

    assign w_exp_q    = vec_q(r_vec_idx);
    // Case inequality so that X/Z on the flop outputs counts as an error
    assign w_mismatch = (q_in !== w_exp_q) || (qbar_in !== ~q_in);

    always_comb begin
        w_next    = r_state;
        w_vec_idx = r_vec_idx;
        w_loop    = r_loop;
        w_err     = r_err;
        w_s       = 1'b0;
        w_r       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_err      = '0;
                    w_vec_idx  = '0;
                    w_loop     = '0;
                    {w_r, w_s} = vec_rs(3'd0);
                    w_next     = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_mismatch && (r_err != '1)) begin
                    w_err = r_err + ERR_W'(1);
                end
                if (r_vec_idx < 3'd5) begin
                    w_vec_idx  = r_vec_idx + 3'd1;
                    {w_r, w_s} = vec_rs(r_vec_idx + 3'd1);
                    w_next     = S_DRIVE;
                end else if (r_loop < 4'(NUM_LOOPS - 1)) begin
                    w_loop     = r_loop + 4'd1;
                    w_vec_idx  = '0;
                    {w_r, w_s} = vec_rs(3'd0);
                    w_next     = S_DRIVE;
                end else begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_vec_idx <= '0;
            r_loop    <= '0;
            r_err     <= '0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_vec_idx <= w_vec_idx;
            r_loop    <= w_loop;
            r_err     <= w_err;
            r_s       <= w_s;
            r_r       <= w_r;
        end
    end

    assign s_out     = r_s;
    assign r_out     = r_r;
    assign busy      = (r_state == S_DRIVE) || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE);
    assign pass      = (r_state == S_DONE) && (r_err == '0);
    assign err_count = r_err;
    assign vec_idx   = r_vec_idx;

endmodule

// File: tb/tb_sr_ff_exerciser.sv
// tb_sr_ff_exerciser
//   Two exercisers, each paired with a behavioural SR flop whose outputs can
//   be faulted. The first exerciser uses NUM_LOOPS=1 and ERR_W=8. The second
//   uses NUM_LOOPS=2 and ERR_W=3, so that a fully faulty flop saturates its
//   counter.
//   Flop modes: 0 correct, 1 q stuck at 0, 2 q stuck at 1, 3 qbar tied to q.
module tb_sr_ff_exerciser;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic       s0, r0, s1, r1;
    logic       q0, qb0, q1, qb1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] ec0;
    logic [2:0] ec1;
    logic [2:0] vi0, vi1;
    logic       fq0, fq1;
    int         mode0, mode1;
    int         total = 0;
    int         bad   = 0;

    // Vector table: {r,s} as an integer, and the expected q after each vector
    int tbl_rs[6] = '{1, 0, 2, 0, 1, 2};
    int tbl_q[6]  = '{1, 1, 0, 0, 1, 0};

    always #5 clk = ~clk;

    sr_ff_exerciser #(.NUM_LOOPS(1), .ERR_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .s_out(s0), .r_out(r0),
        .q_in(q0), .qbar_in(qb0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(ec0), .vec_idx(vi0)
    );

    sr_ff_exerciser #(.NUM_LOOPS(2), .ERR_W(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .s_out(s1), .r_out(r1),
        .q_in(q1), .qbar_in(qb1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .vec_idx(vi1)
    );

    // Behavioural SR flops under test
    always @(posedge clk or posedge rst) begin
        if (rst) fq0 <= 1'b0;
        else if (s0 && !r0) fq0 <= 1'b1;
        else if (r0 && !s0) fq0 <= 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) fq1 <= 1'b0;
        else if (s1 && !r1) fq1 <= 1'b1;
        else if (r1 && !s1) fq1 <= 1'b0;
    end

    always_comb begin
        q0 = fq0; qb0 = ~fq0;
        case (mode0)
            1: begin q0 = 1'b0; qb0 = 1'b1; end
            2: begin q0 = 1'b1; qb0 = 1'b0; end
            3: begin q0 = fq0;  qb0 = fq0;  end
            default: ;
        endcase
    end

    always_comb begin
        q1 = fq1; qb1 = ~fq1;
        case (mode1)
            1: begin q1 = 1'b0; qb1 = 1'b1; end
            2: begin q1 = 1'b1; qb1 = 1'b0; end
            3: begin q1 = fq1;  qb1 = fq1;  end
            default: ;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: each vector compares the observed q/qbar against the table,
    // and the total saturates at the counter width.
    function automatic int model_err(input int mode, input int loops, input int ew);
        int c = 0;
        int oq, oqb;
        for (int l = 0; l < loops; l++) begin
            for (int i = 0; i < 6; i++) begin
                case (mode)
                    1:       begin oq = 0;        oqb = 1;            end
                    2:       begin oq = 1;        oqb = 0;            end
                    3:       begin oq = tbl_q[i]; oqb = tbl_q[i];     end
                    default: begin oq = tbl_q[i]; oqb = 1 - tbl_q[i]; end
                endcase
                if (oq != tbl_q[i] || oqb != 1 - oq) c++;
            end
        end
        if (c > (1 << ew) - 1) c = (1 << ew) - 1;
        return c;
    endfunction

    task automatic rd(input int w, output int bz, output int dn, output int ps,
                      output int rs, output int ec, output int vi);
        if (w == 0) begin
            bz = int'(busy0); dn = int'(done0); ps = int'(pass0);
            rs = int'({r0, s0}); ec = int'(ec0); vi = int'(vi0);
        end else begin
            bz = int'(busy1); dn = int'(done1); ps = int'(pass1);
            rs = int'({r1, s1}); ec = int'(ec1); vi = int'(vi1);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 0) start0 = v; else start1 = v;
    endtask

    // Starts a run on exerciser w and follows it edge by edge until done.
    // With hold set, start stays high after the run ends.
    task automatic run_check(input int w, input int mode, input bit hold, input string tag);
        int loops = (w == 0) ? 1 : 2;
        int ew    = (w == 0) ? 8 : 3;
        int expe  = model_err(mode, loops, ew);
        int lim   = 12 * loops;
        int n     = 0;
        int bz, dn, ps, rs, ec, vi;
        @(negedge clk);
        if (w == 0) mode0 = mode; else mode1 = mode;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(w, 1'b0);
        while (n <= lim + 4) begin
            rd(w, bz, dn, ps, rs, ec, vi);
            if (dn != 0) break;
            chk($sformatf("%s busy@%0d", tag, n), bz, 1);
            if (n % 2 == 0)
                chk($sformatf("%s rs@%0d", tag, n), rs, tbl_rs[(n / 2) % 6]);
            else
                chk($sformatf("%s rs_hold@%0d", tag, n), rs, 0);
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("%s latency", tag), n, lim);
        rd(w, bz, dn, ps, rs, ec, vi);
        chk($sformatf("%s err", tag), ec, expe);
        chk($sformatf("%s pass", tag), ps, (expe == 0) ? 1 : 0);
        chk($sformatf("%s vec_idx", tag), vi, 5);
        chk($sformatf("%s rs_done", tag), rs, 0);
        chk($sformatf("%s busy_done", tag), bz, 0);
    endtask

    typedef struct {
        int mode;
        int exp_err;
        int exp_pass;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int bz, dn, ps, rs, ec, vi;
        vecs[0] = '{0, 0, 1};
        vecs[1] = '{1, 3, 0};
        vecs[2] = '{2, 3, 0};
        vecs[3] = '{3, 6, 0};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 0; mode1 = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            rd(w, bz, dn, ps, rs, ec, vi);
            chk($sformatf("reset%0d", w), bz + dn + ps + rs + ec + vi, 0);
        end
        @(negedge clk); rst = 1'b0;

        // Table-driven: fixed flop faults on the single-loop exerciser
        for (int i = 0; i < 4; i++) begin
            run_check(0, vecs[i].mode, 1'b0, $sformatf("tbl%0d", i));
            rd(0, bz, dn, ps, rs, ec, vi);
            chk($sformatf("tbl%0d err_const", i), ec, vecs[i].exp_err);
            chk($sformatf("tbl%0d pass_const", i), ps, vecs[i].exp_pass);
        end

        // Results hold in DONE while start stays low
        repeat (3) @(posedge clk);
        #1;
        rd(0, bz, dn, ps, rs, ec, vi);
        chk("done_hold", dn, 1);
        chk("err_hold", ec, 6);

        // Reset in the middle of a run
        @(negedge clk); mode0 = 0; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (5) @(posedge clk);
        #2; rst = 1'b1; #1;
        rd(0, bz, dn, ps, rs, ec, vi);
        chk("midrst busy", bz, 0);
        chk("midrst done", dn, 0);
        chk("midrst pass", ps, 0);
        chk("midrst rs", rs, 0);
        chk("midrst vec", vi, 0);
        @(negedge clk); rst = 1'b0;
        run_check(0, 0, 1'b0, "after_rst");

        // Two loops, stuck-at-0, start held through the run and into DONE
        run_check(1, 1, 1'b1, "held");
        @(posedge clk); #1;
        rd(1, bz, dn, ps, rs, ec, vi);
        chk("restart done", dn, 0);
        chk("restart busy", bz, 1);
        chk("restart err", ec, 0);
        chk("restart vec", vi, 0);
        chk("restart rs", rs, 1);
        @(negedge clk); start1 = 1'b0;
        begin
            int k = 0;
            while (k < 40 && done1 !== 1'b1) begin
                @(posedge clk); #1;
                k++;
            end
            chk("restart finishes", int'(done1), 1);
        end

        // Saturation on the 3-bit counter: 12 mismatches clamp to 7
        run_check(1, 3, 1'b0, "sat");

        // Randomised runs checked against the reference model
        for (int it = 0; it < 12; it++) begin
            int w  = $urandom_range(0, 1);
            int md = $urandom_range(0, 3);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_check(w, md, 1'b0, $sformatf("rnd%0d_w%0d_m%0d", it, w, md));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
